// File: rtl/flash_dspi_burst.sv
// Dual-I/O (0xBB) SPI flash burst reader: word-addressed requests, 1..MAX_BURST words per burst.
// Define FLASH_DSPI_CRM_EN to enable continuous-read mode (M=0x20); otherwise every burst sends CMD.
module flash_dspi_burst #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 22,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              flash_clk,
  input  logic              flash_resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              init_done,
  output logic              mspi_cs,
  inout  wire               mspi_di,
  inout  wire               mspi_do,
  output logic [3:0]        dbg_state
);

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_valid is ignored otherwise, and rd_valid is a one-cycle strobe with no backpressure.

  localparam int BPW   = DATA_W / 8;
  localparam int SHIFT = $clog2(BPW);
  localparam int HALF  = DATA_W / 2;
  localparam logic [7:0] CMD_BYTE = 8'hBB;
`ifdef FLASH_DSPI_CRM_EN
  localparam logic [7:0] MODE_BYTE = 8'h20;
`else
  localparam logic [7:0] MODE_BYTE = 8'h00;
`endif

  typedef enum logic [3:0] {
    S_RST, S_INIT, S_IDLE, S_CMD, S_ADDR, S_MODE, S_WAIT, S_DATA, S_GAP
  } state_t;

  state_t             state, state_next;
  logic [4:0]         cnt;
  logic [LEN_W-1:0]   words_left, len_eff;
  logic [23:0]        byte_addr;
  logic [DATA_W-1:0]  shreg, shift_in;
  logic               crm_active, word_end;
  logic               io0_oe, io1_oe, io0_o, io1_o;
  logic [3:0]         dibit_idx;

  assign dbg_state = state;
  assign shift_in  = {shreg[DATA_W-3:0], mspi_do, mspi_di};
  assign word_end  = (state == S_DATA) && (cnt == 5'(HALF - 1));
  assign dibit_idx = 4'(5'd11 - cnt);
  assign mspi_di   = io0_oe ? io0_o : 1'bz;
  assign mspi_do   = io1_oe ? io1_o : 1'bz;

  always_comb begin
    if (req_len == '0)                          len_eff = LEN_W'(1);
    else if (req_len > LEN_W'(MAX_BURST))       len_eff = LEN_W'(MAX_BURST);
    else                                        len_eff = req_len;
  end

  // State register and phase counter
  always_ff @(posedge flash_clk) begin
    if (!flash_resetn) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE || word_end) cnt <= '0;
      else                                                     cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:  state_next = S_INIT;
      S_INIT: if (cnt == 5'd17) state_next = S_IDLE;
      S_IDLE: if (req_valid) state_next = crm_active ? S_ADDR : S_CMD;
      S_CMD:  if (cnt == 5'd7) state_next = S_ADDR;
      S_ADDR: if (cnt == 5'd11) state_next = S_MODE;
      S_MODE: if (cnt == 5'd3) state_next = S_WAIT;
      S_WAIT: state_next = S_DATA;
      S_DATA: if (word_end && words_left == LEN_W'(1)) state_next = S_GAP;
      S_GAP:  state_next = S_IDLE;
      default: state_next = S_RST;
    endcase
  end

  always_comb begin
    mspi_cs   = 1'b1;
    io0_oe    = 1'b0;
    io1_oe    = 1'b0;
    io0_o     = 1'b0;
    io1_o     = 1'b0;
    req_ready = (state == S_IDLE);
    init_done = (state != S_RST) && (state != S_INIT);
    busy      = (state == S_CMD) || (state == S_ADDR) || (state == S_MODE) ||
                (state == S_WAIT) || (state == S_DATA);
    case (state)
      S_INIT: if (cnt < 5'd16) begin
        mspi_cs = 1'b0;
        io0_oe  = 1'b1;
        io0_o   = 1'b1;
      end
      S_CMD: begin
        mspi_cs = 1'b0;
        io0_oe  = 1'b1;
        io0_o   = CMD_BYTE[~cnt[2:0]];
      end
      S_ADDR: begin
        mspi_cs = 1'b0;
        io0_oe  = 1'b1;
        io1_oe  = 1'b1;
        io1_o   = byte_addr[{dibit_idx, 1'b1}];
        io0_o   = byte_addr[{dibit_idx, 1'b0}];
      end
      S_MODE: begin
        mspi_cs = 1'b0;
        // last mode cycle is bus turnaround: flash starts driving after it
        if (cnt < 5'd3) begin
          io0_oe = 1'b1;
          io1_oe = 1'b1;
          io1_o  = MODE_BYTE[{~cnt[1:0], 1'b1}];
          io0_o  = MODE_BYTE[{~cnt[1:0], 1'b0}];
        end
      end
      S_WAIT, S_DATA: mspi_cs = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge flash_clk) begin
    if (!flash_resetn) begin
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
      shreg      <= '0;
      byte_addr  <= '0;
      words_left <= '0;
      crm_active <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (state == S_IDLE && req_valid) begin
        byte_addr  <= 24'(req_addr) << SHIFT;
        words_left <= len_eff;
      end
      if (state == S_MODE && cnt == 5'd3 && MODE_BYTE[5:4] == 2'b10) crm_active <= 1'b1;
      if (state == S_DATA) begin
        shreg <= shift_in;
        if (word_end) begin
          rd_data    <= shift_in;
          rd_valid   <= 1'b1;
          rd_last    <= (words_left == LEN_W'(1));
          words_left <= words_left - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_dspi_burst.sv
// Bench for flash_dspi_burst: a per-cycle flash device model with a byte-memory image and a word scoreboard.
module tb_flash_dspi_burst;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 23;
  localparam int MAX_BURST = 8;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);
  localparam int BPW       = DATA_W / 8;
  localparam int SHIFT     = $clog2(BPW);
  localparam int HALF      = DATA_W / 2;
`ifdef FLASH_DSPI_CRM_EN
  localparam bit         CRM   = 1'b1;
  localparam logic [7:0] M_EXP = 8'h20;
`else
  localparam bit         CRM   = 1'b0;
  localparam logic [7:0] M_EXP = 8'h00;
`endif

  logic              flash_clk, flash_resetn, req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rd_valid, rd_last, busy, init_done, mspi_cs;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        dbg_state;
  wire               mspi_di, mspi_do;
  logic              tb_oe, tb_d0, tb_d1;

  int tests = 0;
  int fails = 0;
  bit crm_exp = 1'b0;
  logic [7:0]        salt;
  logic [7:0]        mem_ov [logic [23:0]];
  logic [DATA_W-1:0] exp_q [$];

  assign mspi_di = tb_oe ? tb_d0 : 1'bz;
  assign mspi_do = tb_oe ? tb_d1 : 1'bz;

  flash_dspi_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .flash_clk(flash_clk), .flash_resetn(flash_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .init_done(init_done), .mspi_cs(mspi_cs),
    .mspi_di(mspi_di), .mspi_do(mspi_do), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    flash_clk = 1'b0;
    forever #5 flash_clk = ~flash_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] b);
    if (mem_ov.exists(b)) return mem_ov[b];
    return b[7:0] ^ b[15:8] ^ b[23:16] ^ salt;
  endfunction

  // Flash streams bytes in ascending address order, MSB first; 24-bit wrap.
  function automatic logic [DATA_W-1:0] word_at(input logic [23:0] b);
    logic [DATA_W-1:0] wv = '0;
    for (int i = 0; i < BPW; i++) wv = (wv << 8) | DATA_W'(mem_byte(b + 24'(i)));
    return wv;
  endfunction

  task automatic reset_and_init();
    flash_resetn = 1'b0;
    req_valid    = 1'b0;
    tb_oe        = 1'b0;
    crm_exp      = 1'b0;
    repeat (3) @(negedge flash_clk);
    chk("rst_cs", 32'(mspi_cs), 1);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    flash_resetn = 1'b1;
    @(negedge flash_clk);
    for (int c = 0; c <= 18; c++) begin
      chk("init_cs", 32'(mspi_cs), (c < 16) ? 0 : 1);
      if (c < 16) chk("init_io0", 32'(mspi_di), 1);
      chk("init_done", 32'(init_done), (c >= 18) ? 1 : 0);
      chk("init_ready", 32'(req_ready), (c >= 18) ? 1 : 0);
      if (c < 18) @(negedge flash_clk);
    end
  endtask

  // One burst. abort_at > 0 asserts reset during cycle A+abort_at.
  task automatic run_req(input logic [ADDR_W-1:0] a, input int len_in, input int abort_at);
    int n, cmd_n, data_p, end_p, lim, d;
    logic exp_rv;
    logic [23:0] baddr, got_addr;
    logic [7:0]  got_cmd;
    logic [5:0]  got_mode;
    logic [DATA_W-1:0] wrds [MAX_BURST];
    n      = (len_in == 0) ? 1 : ((len_in > MAX_BURST) ? MAX_BURST : len_in);
    cmd_n  = crm_exp ? 0 : 8;
    data_p = cmd_n + 17;
    end_p  = data_p + n * HALF;
    baddr  = 24'(a) << SHIFT;
    exp_q.delete();
    for (int w = 0; w < n; w++) begin
      wrds[w] = word_at(baddr + 24'(w * BPW));
      exp_q.push_back(wrds[w]);
    end
    lim = 0;
    while (!req_ready && lim < 100) begin
      @(negedge flash_clk);
      lim++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 1);
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = LEN_W'(len_in);
    @(negedge flash_clk);
    req_valid = 1'b0;
    got_cmd = '0; got_addr = '0; got_mode = '0;
    for (int p = 0; p <= end_p; p++) begin
      if (p + 1 == abort_at) begin
        flash_resetn = 1'b0;
        tb_oe        = 1'b0;
        crm_exp      = 1'b0;
        @(negedge flash_clk);
        chk("abort_cs", 32'(mspi_cs), 1);
        chk("abort_rd_valid", 32'(rd_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_init_done", 32'(init_done), 0);
        return;
      end
      if (p < end_p) begin
        chk("cs_low", 32'(mspi_cs), 0);
        chk("busy_high", 32'(busy), 1);
      end
      if (p < cmd_n) got_cmd = {got_cmd[6:0], mspi_di};
      else if (p < cmd_n + 12) got_addr = {got_addr[21:0], mspi_do, mspi_di};
      else if (p < cmd_n + 15) got_mode = {got_mode[3:0], mspi_do, mspi_di};
      else if (p == cmd_n + 16) begin
        if (cmd_n != 0) chk("cmd_byte", 32'(got_cmd), 32'h0BB);
        chk("addr_bytes", 32'(got_addr), 32'(baddr));
        chk("mode_bits", 32'(got_mode), 32'(M_EXP[7:2]));
      end
      if (p >= data_p && p < end_p) begin
        d = p - data_p;
        tb_oe = 1'b1;
        {tb_d1, tb_d0} = wrds[d / HALF][DATA_W - 1 - 2 * (d % HALF) -: 2];
      end else begin
        tb_oe = 1'b0;
      end
      d = p - data_p;
      exp_rv = (d > 0) && (d % HALF == 0);
      chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        chk("rd_last", 32'(rd_last), (d == n * HALF) ? 1 : 0);
      end
      if (p == end_p) begin
        chk("cs_release", 32'(mspi_cs), 1);
        chk("busy_release", 32'(busy), 0);
        chk("ready_gap", 32'(req_ready), 0);
      end
      @(negedge flash_clk);
    end
    chk("ready_back", 32'(req_ready), 1);
    chk("words_all_seen", 32'(exp_q.size()), 0);
    if (CRM) crm_exp = 1'b1;
  endtask

  // directed sequence
  initial begin
    tb_oe = 1'b0; tb_d0 = 1'b0; tb_d1 = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    flash_resetn = 1'b0;
    salt = 8'($urandom);
    mem_ov[24'h100000] = 8'hA5;
    mem_ov[24'h100001] = 8'h5A;

    reset_and_init();
    run_req(ADDR_W'(24'h080000), 1, 0);
    run_req(ADDR_W'($urandom), 1, 0);
    run_req(ADDR_W'(24'h7FFFFE), 4, 0);
    run_req(ADDR_W'($urandom), 0, 0);
    run_req(ADDR_W'($urandom), MAX_BURST + 3, 0);
    for (int i = 0; i < 6; i++) run_req(ADDR_W'($urandom), $urandom_range(0, MAX_BURST + 3), 0);
    run_req(ADDR_W'($urandom), 4, 28);
    reset_and_init();
    run_req(ADDR_W'($urandom), 2, 0);
    run_req(ADDR_W'($urandom), $urandom_range(1, MAX_BURST), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
